// File: rtl/msx_slot_bus_bridge_pkg.sv
// Shared types and constants for the MSX slot-to-internal-bus bridge.
package msx_bus_pkg;

  // Bridge sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_HOLD = 2'd2,
    ST_WR_HOLD = 2'd3
  } bridge_state_t;

  // Width of the read timeout counter
  localparam int CNT_W = 8;

  // Value returned to the host when no target answers a read
  localparam logic [7:0] DATA_INACTIVE = 8'hFF;

  // Selects the chip-select that belongs to the decoded address space
  function automatic logic select_cs(input logic mem, input logic mem_cs, input logic io_cs);
    return mem ? mem_cs : io_cs;
  endfunction

endpackage

// File: rtl/msx_slot_bus_bridge_if.sv
// Internal MSX-50BUS signal bundle between the bridge (master) and targets (slave).
interface msx_bus_if;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_read;
  logic        bus_write;
  logic        bus_memory;
  logic        bus_io;
  logic        bus_memory_cs;
  logic        bus_io_cs;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;

  modport master (
    output bus_address, bus_write_data, bus_read, bus_write, bus_memory, bus_io,
    input  bus_memory_cs, bus_io_cs, bus_read_ready, bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data, bus_read, bus_write, bus_memory, bus_io,
    output bus_memory_cs, bus_io_cs, bus_read_ready, bus_read_data
  );
endinterface

// File: rtl/msx_slot_bus_bridge_sync.sv
// Two-flop synchronizer for asynchronous slot controls; resets to the
// inactive (all-ones) level so active-low strobes look released.
module slot_signal_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= {WIDTH{1'b1}};
      sync_q <= {WIDTH{1'b1}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/msx_slot_bus_bridge.sv
// Bridges asynchronous Z80 cartridge-slot cycles onto single-cycle internal
// bus strobes, returns read data to the slot and holds the host in wait
// while a read is outstanding (bounded by a timeout).
module msx_slot_bus_bridge
  import msx_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        n_slot_sltsl,
  input  logic        n_slot_merq,
  input  logic        n_slot_iorq,
  input  logic        n_slot_m1,
  input  logic        n_slot_rd,
  input  logic        n_slot_wr,
  input  logic [15:0] slot_a,
  input  logic [7:0]  slot_d_in,
  output logic [7:0]  slot_d_out,
  output logic        slot_d_oe,
  output logic        n_slot_wait,
  msx_bus_if.master   bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [5:0] ctl_raw_s;
  logic [5:0] ctl_sync_s;

  assign ctl_raw_s = {n_slot_sltsl, n_slot_merq, n_slot_iorq, n_slot_m1, n_slot_rd, n_slot_wr};

  slot_signal_sync #(.WIDTH(6)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ctl_raw_s),
    .q     (ctl_sync_s)
  );

  // Decoded access on the synchronized controls; IORQ with M1 low is an
  // interrupt acknowledge and is not an I/O access.
  logic mem_s, io_s, acc_s, rd_s, wr_s;
  assign mem_s = !ctl_sync_s[5] && !ctl_sync_s[4];
  assign io_s  = !ctl_sync_s[3] && ctl_sync_s[2];
  assign acc_s = mem_s || io_s;
  assign rd_s  = !ctl_sync_s[1];
  assign wr_s  = !ctl_sync_s[0];

  bridge_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_q, cs_d;
  logic             bus_read_q, bus_read_d;
  logic             bus_write_q, bus_write_d;
  logic             bus_memory_q, bus_memory_d;
  logic             bus_io_q, bus_io_d;
  logic [15:0]      bus_address_q, bus_address_d;
  logic [7:0]       bus_write_data_q, bus_write_data_d;
  logic [7:0]       slot_d_out_q, slot_d_out_d;
  logic             slot_d_oe_q, slot_d_oe_d;
  logic             n_slot_wait_q, n_slot_wait_d;

  // Next-state and next-output computation; strobes default low each cycle
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cs_d             = cs_q;
    bus_read_d       = 1'b0;
    bus_write_d      = 1'b0;
    bus_memory_d     = 1'b0;
    bus_io_d         = 1'b0;
    bus_address_d    = 16'h0000;
    bus_write_data_d = 8'h00;
    slot_d_out_d     = slot_d_out_q;
    slot_d_oe_d      = slot_d_oe_q;
    n_slot_wait_d    = n_slot_wait_q;

    case (state_q)
      ST_IDLE: begin
        slot_d_oe_d   = 1'b0;
        n_slot_wait_d = 1'b1;
        if (acc_s && rd_s && !wr_s) begin
          bus_read_d    = 1'b1;
          bus_memory_d  = mem_s;
          bus_io_d      = io_s;
          bus_address_d = slot_a;
          n_slot_wait_d = 1'b0;
          cs_d          = select_cs(mem_s, bus.bus_memory_cs, bus.bus_io_cs);
          cnt_d         = {CNT_W{1'b0}};
          state_d       = ST_RD_WAIT;
        end else if (acc_s && wr_s && !rd_s) begin
          bus_write_d      = 1'b1;
          bus_memory_d     = mem_s;
          bus_io_d         = io_s;
          bus_address_d    = slot_a;
          bus_write_data_d = slot_d_in;
          state_d          = ST_WR_HOLD;
        end else if (acc_s && rd_s && wr_s) begin
          // Contradictory strobes: issue nothing, wait for the host to let go
          state_d = ST_WR_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (bus.bus_read_ready) begin
          slot_d_out_d  = bus.bus_read_data;
          slot_d_oe_d   = cs_q;
          n_slot_wait_d = 1'b1;
          state_d       = ST_RD_HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          slot_d_out_d  = DATA_INACTIVE;
          slot_d_oe_d   = 1'b0;
          n_slot_wait_d = 1'b1;
          state_d       = ST_RD_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RD_HOLD: begin
        if (!rd_s) begin
          slot_d_oe_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RD_HOLD;
        end
      end
      ST_WR_HOLD: begin
        if (!rd_s && !wr_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_HOLD;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        slot_d_oe_d   = 1'b0;
        n_slot_wait_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= {CNT_W{1'b0}};
      cs_q             <= 1'b0;
      bus_read_q       <= 1'b0;
      bus_write_q      <= 1'b0;
      bus_memory_q     <= 1'b0;
      bus_io_q         <= 1'b0;
      bus_address_q    <= 16'h0000;
      bus_write_data_q <= 8'h00;
      slot_d_out_q     <= 8'h00;
      slot_d_oe_q      <= 1'b0;
      n_slot_wait_q    <= 1'b1;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cs_q             <= cs_d;
      bus_read_q       <= bus_read_d;
      bus_write_q      <= bus_write_d;
      bus_memory_q     <= bus_memory_d;
      bus_io_q         <= bus_io_d;
      bus_address_q    <= bus_address_d;
      bus_write_data_q <= bus_write_data_d;
      slot_d_out_q     <= slot_d_out_d;
      slot_d_oe_q      <= slot_d_oe_d;
      n_slot_wait_q    <= n_slot_wait_d;
    end
  end

  assign bus.bus_read       = bus_read_q;
  assign bus.bus_write      = bus_write_q;
  assign bus.bus_memory     = bus_memory_q;
  assign bus.bus_io         = bus_io_q;
  assign bus.bus_address    = bus_address_q;
  assign bus.bus_write_data = bus_write_data_q;
  assign slot_d_out         = slot_d_out_q;
  assign slot_d_oe          = slot_d_oe_q;
  assign n_slot_wait        = n_slot_wait_q;

endmodule

// File: tb/tb_msx_slot_bus_bridge.sv
// Scoreboard bench for msx_slot_bus_bridge: stimulus pushes expected strobes
// and read responses, a negedge monitor pops and compares them.
module tb_msx_slot_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        n_slot_sltsl, n_slot_merq, n_slot_iorq, n_slot_m1, n_slot_rd, n_slot_wr;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_in;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic        n_slot_wait;

  msx_bus_if bus_if ();

  msx_slot_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .n_slot_sltsl (n_slot_sltsl),
    .n_slot_merq  (n_slot_merq),
    .n_slot_iorq  (n_slot_iorq),
    .n_slot_m1    (n_slot_m1),
    .n_slot_rd    (n_slot_rd),
    .n_slot_wr    (n_slot_wr),
    .slot_a       (slot_a),
    .slot_d_in    (slot_d_in),
    .slot_d_out   (slot_d_out),
    .slot_d_oe    (slot_d_oe),
    .n_slot_wait  (n_slot_wait),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    bit          mem;
    bit          io;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          cyc;
  } strobe_t;

  typedef struct {
    logic [7:0] d;
    bit         oe;
    int         lat;
  } resp_t;

  strobe_t sq[$];
  resp_t   rq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every strobe and every wait release against the queues
  bit prev_wait   = 1'b1;
  bit prev_strobe = 1'b0;
  int strobe_cyc  = 0;
  always @(negedge clk) begin
    strobe_t e;
    resp_t   r;
    if (reset) begin
      prev_wait   = n_slot_wait;
      prev_strobe = 1'b0;
    end else begin
      if (bus_if.bus_read || bus_if.bus_write) begin
        if (sq.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = sq.pop_front();
          check("strobe_kind", {30'd0, bus_if.bus_write, bus_if.bus_read}, {30'd0, e.is_write, !e.is_write});
          check("strobe_qual", {30'd0, bus_if.bus_memory, bus_if.bus_io}, {30'd0, e.mem, e.io});
          check("strobe_addr", {16'd0, bus_if.bus_address}, {16'd0, e.addr});
          check("strobe_wdata", {24'd0, bus_if.bus_write_data}, {24'd0, e.wd});
          check("strobe_latency", cyc, e.cyc);
          if (bus_if.bus_read) check("wait_with_strobe", {31'd0, n_slot_wait}, 32'd0);
        end
        strobe_cyc = cyc;
      end else if (prev_strobe) begin
        check("post_strobe_clear",
              {6'd0, bus_if.bus_memory, bus_if.bus_io, bus_if.bus_write_data, bus_if.bus_address},
              32'd0);
      end
      if (!prev_wait && n_slot_wait) begin
        if (rq.size() == 0) begin
          check("unexpected_wait_release", 32'd1, 32'd0);
        end else begin
          r = rq.pop_front();
          check("resp_data", {24'd0, slot_d_out}, {24'd0, r.d});
          check("resp_oe", {31'd0, slot_d_oe}, {31'd0, r.oe});
          check("wait_length", cyc - strobe_cyc, r.lat);
        end
      end
      prev_wait   = n_slot_wait;
      prev_strobe = bus_if.bus_read || bus_if.bus_write;
    end
  end

  task automatic push_strobe(input bit w, input bit m, input bit i, input logic [15:0] a, input logic [7:0] d);
    strobe_t e;
    e.is_write = w; e.mem = m; e.io = i; e.addr = a; e.wd = d; e.cyc = cyc + 3;
    sq.push_back(e);
  endtask

  task automatic push_resp(input logic [7:0] d, input bit oe, input int lat);
    resp_t r;
    r.d = d; r.oe = oe; r.lat = lat;
    rq.push_back(r);
  endtask

  // Waits at negedges for a read strobe, bounded
  task automatic wait_read_strobe();
    int n = 0;
    while (!bus_if.bus_read && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.bus_read) check("read_strobe_timeout", 32'd0, 32'd1);
  endtask

  // Pulses ready for one cycle, captured two clocks after the strobe edge
  task automatic ready_pulse(input logic [7:0] d);
    @(negedge clk);
    bus_if.bus_read_data  = d;
    bus_if.bus_read_ready = 1'b1;
    @(negedge clk);
    bus_if.bus_read_ready = 1'b0;
  endtask

  task automatic idle_slot();
    n_slot_sltsl = 1'b1; n_slot_merq = 1'b1; n_slot_iorq = 1'b1;
    n_slot_m1 = 1'b1; n_slot_rd = 1'b1; n_slot_wr = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_slot();
    slot_a = 16'h0000; slot_d_in = 8'h00;
    bus_if.bus_memory_cs = 1'b0; bus_if.bus_io_cs = 1'b0;
    bus_if.bus_read_ready = 1'b0; bus_if.bus_read_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wait", {31'd0, n_slot_wait}, 32'd1);
    check("rst_oe", {31'd0, slot_d_oe}, 32'd0);
    check("rst_dout", {24'd0, slot_d_out}, 32'd0);
    check("rst_strobes", {30'd0, bus_if.bus_read, bus_if.bus_write}, 32'd0);
    check("rst_addr", {16'd0, bus_if.bus_address}, 32'd0);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Memory write held for 10 clocks: one pulse only
    n_slot_sltsl = 1'b0; n_slot_merq = 1'b0; slot_a = 16'h4000; slot_d_in = 8'h5A;
    push_strobe(1'b1, 1'b1, 1'b0, 16'h4000, 8'h5A);
    n_slot_wr = 1'b0;
    repeat (10) @(negedge clk);
    idle_slot();
    repeat (4) @(negedge clk);

    // Memory read answered two clocks after the strobe
    bus_if.bus_memory_cs = 1'b1;
    n_slot_sltsl = 1'b0; n_slot_merq = 1'b0; slot_a = 16'h8000;
    push_strobe(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);
    push_resp(8'hA5, 1'b1, 2);
    n_slot_rd = 1'b0;
    @(negedge clk);
    wait_read_strobe();
    ready_pulse(8'hA5);
    repeat (3) @(negedge clk);
    check("mem_rd_hold_oe", {31'd0, slot_d_oe}, 32'd1);
    check("mem_rd_hold_data", {24'd0, slot_d_out}, 32'hA5);
    n_slot_rd = 1'b1;
    repeat (4) @(negedge clk);
    check("mem_rd_release_oe", {31'd0, slot_d_oe}, 32'd0);
    idle_slot();
    repeat (3) @(negedge clk);

    // I/O read with no target: timeout after 16 clocks
    bus_if.bus_io_cs = 1'b0;
    n_slot_iorq = 1'b0; slot_a = 16'h0098;
    push_strobe(1'b0, 1'b0, 1'b1, 16'h0098, 8'h00);
    push_resp(8'hFF, 1'b0, 16);
    n_slot_rd = 1'b0;
    repeat (24) @(negedge clk);
    check("io_timeout_wait", {31'd0, n_slot_wait}, 32'd1);
    check("io_timeout_data", {24'd0, slot_d_out}, 32'hFF);
    // Ready outside RD_WAIT must be ignored
    ready_pulse(8'h33);
    @(negedge clk);
    check("late_ready_ignored", {24'd0, slot_d_out}, 32'hFF);
    check("io_timeout_oe", {31'd0, slot_d_oe}, 32'd0);
    idle_slot();
    repeat (4) @(negedge clk);

    // Interrupt acknowledge: no strobe
    n_slot_iorq = 1'b0; n_slot_m1 = 1'b0; n_slot_rd = 1'b0;
    repeat (8) @(negedge clk);
    check("intack_wait", {31'd0, n_slot_wait}, 32'd1);
    idle_slot();
    repeat (3) @(negedge clk);

    // Memory request without slot select: no strobe
    n_slot_merq = 1'b0; n_slot_rd = 1'b0;
    repeat (8) @(negedge clk);
    check("unselected_wait", {31'd0, n_slot_wait}, 32'd1);
    idle_slot();
    repeat (3) @(negedge clk);

    // rd and wr together: nothing; then a clean write
    n_slot_sltsl = 1'b0; n_slot_merq = 1'b0; slot_a = 16'h1111;
    n_slot_rd = 1'b0; n_slot_wr = 1'b0;
    repeat (8) @(negedge clk);
    check("rdwr_wait", {31'd0, n_slot_wait}, 32'd1);
    n_slot_rd = 1'b1; n_slot_wr = 1'b1;
    repeat (4) @(negedge clk);
    slot_a = 16'h1234; slot_d_in = 8'hC3;
    push_strobe(1'b1, 1'b1, 1'b0, 16'h1234, 8'hC3);
    n_slot_wr = 1'b0;
    repeat (6) @(negedge clk);
    idle_slot();
    repeat (4) @(negedge clk);

    // Reset while a read is outstanding
    bus_if.bus_memory_cs = 1'b1;
    n_slot_sltsl = 1'b0; n_slot_merq = 1'b0; slot_a = 16'h2000;
    push_strobe(1'b0, 1'b1, 1'b0, 16'h2000, 8'h00);
    n_slot_rd = 1'b0;
    @(negedge clk);
    wait_read_strobe();
    repeat (3) @(negedge clk);
    check("pre_reset_wait", {31'd0, n_slot_wait}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_wait", {31'd0, n_slot_wait}, 32'd1);
    check("async_rst_oe", {31'd0, slot_d_oe}, 32'd0);
    check("async_rst_strobes", {30'd0, bus_if.bus_read, bus_if.bus_write}, 32'd0);
    idle_slot();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_slot_sltsl = 1'b0; n_slot_merq = 1'b0; slot_a = 16'h3000;
    push_strobe(1'b0, 1'b1, 1'b0, 16'h3000, 8'h00);
    push_resp(8'h5C, 1'b1, 2);
    n_slot_rd = 1'b0;
    @(negedge clk);
    wait_read_strobe();
    ready_pulse(8'h5C);
    repeat (2) @(negedge clk);
    check("post_reset_read_data", {24'd0, slot_d_out}, 32'h5C);
    idle_slot();
    repeat (5) @(negedge clk);

    check("strobe_queue_empty", sq.size(), 32'd0);
    check("resp_queue_empty", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
